// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite encodings and the DMA controller state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        ERR
    } dma_state_t;

endpackage

// File: rtl/axi_lite_wdog.sv
// Handshake watchdog: down-counter reloaded on clear, expires at terminal count 0.
module axi_lite_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge aclk) begin
        if (areset || clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Loaded with TIMEOUT-1, so expiry is seen in the TIMEOUT-th enabled cycle.
    assign expired = enable && (count == '0);

endmodule

// File: rtl/axi_lite_dma_master.sv
// AXI4-Lite word-copy initiator: one read then one write per word, one transaction in flight.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for start; len=0 completes here with a done pulse
//  RD_ADDR | arvalid up with araddr=cur_src
//  RD_DATA | rready up, capture rdata
//  WR      | awvalid/wvalid up, each drops after its own handshake
//  WR_RESP | bready up, advance pointers on OKAY
//  ERR     | one cycle: err latched, everything dropped
module axi_lite_dma_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 256
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    dma_state_t state, next_state;

    logic [ADDR_W-1:0] cur_src, cur_dst, err_addr_q;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;
    logic              aw_done, w_done;
    logic              done_q, err_q;
    logic              aw_hs, w_hs, wr_both;
    logic              wdog_expired;

    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

    axi_lite_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .aclk   (aclk),
        .areset (areset),
        .clear  (next_state != state),
        .enable (busy),
        .expired(wdog_expired)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start && (len_words != '0)) next_state = RD_ADDR;
            end
            RD_ADDR: begin
                if (m_axi_arready)     next_state = RD_DATA;
                else if (wdog_expired) next_state = ERR;
            end
            RD_DATA: begin
                if (m_axi_rvalid)      next_state = (m_axi_rresp == RESP_OKAY) ? WR : ERR;
                else if (wdog_expired) next_state = ERR;
            end
            WR: begin
                if (wr_both)           next_state = WR_RESP;
                else if (wdog_expired) next_state = ERR;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY)     next_state = ERR;
                    else if (remaining == LEN_W'(1)) next_state = IDLE;
                    else                              next_state = RD_ADDR;
                end else if (wdog_expired) begin
                    next_state = ERR;
                end
            end
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        unique case (state)
            RD_ADDR: begin
                busy          = 1'b1;
                m_axi_arvalid = 1'b1;
            end
            RD_DATA: begin
                busy         = 1'b1;
                m_axi_rready = 1'b1;
            end
            WR: begin
                busy          = 1'b1;
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
            end
            WR_RESP: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            data_q     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if ((state == IDLE) && start) begin
                cur_src   <= {src_addr[ADDR_W-1:2], 2'b00};
                cur_dst   <= {dst_addr[ADDR_W-1:2], 2'b00};
                remaining <= len_words;
                err_q     <= 1'b0;
                done_q    <= (len_words == '0);
            end
            if ((state == RD_DATA) && m_axi_rvalid) begin
                data_q <= m_axi_rdata;
            end
            if (state != WR) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if ((state == WR_RESP) && m_axi_bvalid && (m_axi_bresp == RESP_OKAY)) begin
                cur_src   <= cur_src + ADDR_W'(4);
                cur_dst   <= cur_dst + ADDR_W'(4);
                remaining <= remaining - LEN_W'(1);
                done_q    <= (remaining == LEN_W'(1));
            end
            // Reads fail on the source pointer, writes on the destination pointer.
            if (next_state == ERR) begin
                err_q      <= 1'b1;
                err_addr_q <= ((state == RD_ADDR) || (state == RD_DATA)) ? cur_src : cur_dst;
            end
        end
    end

    assign done         = done_q;
    assign err          = err_q;
    assign err_addr     = err_addr_q;
    assign m_axi_araddr = cur_src;
    assign m_axi_awaddr = cur_dst;
    assign m_axi_wdata  = data_q;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_arprot = PROT_DEFAULT;
    assign m_axi_awprot = PROT_DEFAULT;

endmodule

// File: tb/tb_axi_lite_dma_master.sv
// Bench for axi_lite_dma_master: SRAM responder with stalls, unmapped hole and error injection.
module tb_axi_lite_dma_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 10;
    localparam int TIMEOUT = 256;
    localparam logic [31:0] NONE = 32'hFFFF_FFFC;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic              areset, start;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [LEN_W-1:0]  len_words;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arprot, awprot;
    logic              arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0] rdata, wdata;
    logic [1:0]        rresp, bresp;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]        wstrb;

    axi_lite_dma_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          stall_max = 0;
    logic [31:0] bad_waddr = NONE;
    int          errors = 0, checks = 0;
    int          done_cnt = 0, ar_seen = 0, aw_seen = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          stall;
        logic [31:0] bad;
        bit          intrude;
        bit          fixed_pat;
        bit          exp_err;
        logic [31:0] exp_err_addr;
        int          exp_lat;
    } vec_t;

    function automatic bit mapped(input logic [31:0] a);
        return (a < 32'h1000) && !((a >= 32'h200) && (a < 32'h300));
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    // Responder and protocol monitor: sample at negedge, drive 1 time unit after posedge.
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] hs_araddr, hs_awaddr, hs_wdata;
    bit p_arvalid, p_ar_hs, p_awvalid, p_aw_hs, p_wvalid, p_w_hs, p_rst;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit rd_pend, aw_got, w_got, b_pend;
    logic [31:0] rd_a, wr_a, wr_d;

    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ar_cnt = -1; aw_cnt = -1; w_cnt = -1;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_rst = 1;
        forever begin
            @(negedge aclk);
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            hs_araddr = araddr; hs_awaddr = awaddr; hs_wdata = wdata;
            if (!p_rst) begin
                if (p_arvalid && !p_ar_hs)
                    chk("ar_hold", arvalid ? araddr : {31'b0, !err}, arvalid ? p_araddr : 32'h0);
                if (p_awvalid && !p_aw_hs)
                    chk("aw_hold", awvalid ? awaddr : {31'b0, !err}, awvalid ? p_awaddr : 32'h0);
                if (p_wvalid && !p_w_hs)
                    chk("w_hold", wvalid ? wdata : {31'b0, !err}, wvalid ? p_wdata : 32'h0);
            end
            p_arvalid = arvalid; p_ar_hs = ar_hs; p_araddr = araddr;
            p_awvalid = awvalid; p_aw_hs = aw_hs; p_awaddr = awaddr;
            p_wvalid = wvalid; p_w_hs = w_hs; p_wdata = wdata;
            p_rst = areset;
            if (!areset) begin
                if (done) done_cnt++;
                if (arvalid) ar_seen++;
                if (awvalid || wvalid) aw_seen++;
            end

            @(posedge aclk);
            #1;
            if (areset) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = -1; aw_cnt = -1; w_cnt = -1;
                rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                continue;
            end
            if (r_hs) rvalid = 0;
            if (ar_hs) begin
                arready = 0; ar_cnt = -1; rd_pend = 1; rd_a = hs_araddr;
                r_cnt = int'($urandom_range(stall_max, 0));
            end
            if (rd_pend) begin
                if (r_cnt == 0) begin
                    rvalid = 1; rresp = 2'b00; rdata = mem[idx(rd_a)]; rd_pend = 0;
                end else r_cnt--;
            end
            if (!arvalid) arready = 0;
            else if (mapped(araddr) && !arready) begin
                if (ar_cnt < 0) ar_cnt = int'($urandom_range(stall_max, 0));
                if (ar_cnt == 0) arready = 1; else ar_cnt--;
            end

            if (b_hs) bvalid = 0;
            if (aw_hs) begin awready = 0; aw_cnt = -1; aw_got = 1; wr_a = hs_awaddr; end
            if (w_hs)  begin wready = 0;  w_cnt = -1;  w_got = 1;  wr_d = hs_wdata;  end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1;
                b_cnt = int'($urandom_range(stall_max, 0));
            end
            if (b_pend) begin
                if (b_cnt == 0) begin
                    bvalid = 1; b_pend = 0;
                    if (wr_a == bad_waddr) bresp = 2'b10;
                    else begin bresp = 2'b00; mem[idx(wr_a)] = wr_d; end
                end else b_cnt--;
            end
            if (!awvalid) awready = 0;
            else if (mapped(awaddr) && !awready) begin
                if (aw_cnt < 0) aw_cnt = int'($urandom_range(stall_max, 0));
                if (aw_cnt == 0) awready = 1; else aw_cnt--;
            end
            if (!wvalid) wready = 0;
            else if (mapped(awaddr) && !wready) begin
                if (w_cnt < 0) w_cnt = int'($urandom_range(stall_max, 0));
                if (w_cnt == 0) wready = 1; else w_cnt--;
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input int l, input int st,
                                input logic [31:0] bad, input bit intr, input bit fx, input bit ee,
                                input logic [31:0] ea, input int lat);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.stall = st; v.bad = bad; v.intrude = intr;
        v.fixed_pat = fx; v.exp_err = ee; v.exp_err_addr = ea; v.exp_lat = lat;
        return v;
    endfunction

    // Reference: sequential word copy that stops at the first unmapped or rejected address.
    task automatic run_copy(input vec_t v, input string tag);
        int lat, n;
        bit got;
        logic [31:0] s, d;
        stall_max = v.stall;
        bad_waddr = v.bad;
        for (int i = 0; i < v.len; i++) begin
            s = v.src + 32'(4 * i);
            if (mapped(s)) mem[idx(s)] = v.fixed_pat ? 32'h11 * 32'(i + 1) : $urandom;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < v.len; i++) begin
            s = v.src + 32'(4 * i);
            d = v.dst + 32'(4 * i);
            if (!mapped(s) || !mapped(d) || (d == v.bad)) break;
            ref_mem[idx(d)] = ref_mem[idx(s)];
        end
        done_cnt = 0; ar_seen = 0; aw_seen = 0;
        src_addr = v.src; dst_addr = v.dst; len_words = LEN_W'(v.len); start = 1;
        tick();
        lat = 0; got = 0;
        while (!got && lat < 3000) begin
            if (v.intrude && lat == 3) begin
                start = 1; src_addr = 32'h20; dst_addr = 32'h800; len_words = LEN_W'(1);
            end else start = 0;
            if (done || err) got = 1;
            else begin tick(); lat++; end
        end
        start = 0;
        chk({tag, "_finished"}, {31'b0, got}, 32'h1);
        if (v.exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
        if (v.exp_err) chk({tag, "_err_addr"}, err_addr, v.exp_err_addr);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
        if (v.exp_err) begin ar_seen = 0; aw_seen = 0; end
        repeat (10) tick();
        chk({tag, "_done_pulses"}, 32'(done_cnt), v.exp_err ? 32'h0 : 32'h1);
        if (v.exp_err) chk({tag, "_err_sticky"}, {31'b0, err}, 32'h1);
        if (v.len == 0 || v.exp_err) chk({tag, "_quiet_bus"}, 32'(ar_seen + aw_seen), 32'h0);
        n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
        chk({tag, "_mem"}, 32'(n), 32'h0);
    endtask

    vec_t tbl [8];
    vec_t rv;
    int   k;

    initial begin
        areset = 1; start = 0; src_addr = 0; dst_addr = 0; len_words = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        tbl[0] = mk(32'h000, 32'h100, 4, 0, NONE,   0, 1, 0, 32'h0,   16);
        tbl[1] = mk(32'h000, 32'h140, 0, 0, NONE,   0, 0, 0, 32'h0,   0);
        tbl[2] = mk(32'h040, 32'h400, 8, 5, NONE,   0, 0, 0, 32'h0,   -1);
        tbl[3] = mk(32'h080, 32'h300, 5, 0, 32'h308, 0, 0, 1, 32'h308, 12);
        tbl[4] = mk(32'h000, 32'h500, 3, 2, NONE,   0, 0, 0, 32'h0,   -1);
        tbl[5] = mk(32'h000, 32'h200, 2, 0, NONE,   0, 0, 1, 32'h200, 2 + TIMEOUT);
        tbl[6] = mk(32'h204, 32'h600, 3, 0, NONE,   0, 0, 1, 32'h204, TIMEOUT);
        tbl[7] = mk(32'h010, 32'h700, 3, 3, NONE,   1, 0, 0, 32'h0,   -1);

        repeat (3) tick();
        chk("rst_valids", {27'b0, arvalid, awvalid, wvalid, rready, bready}, 32'h0);
        chk("rst_flags", {29'b0, busy, done, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_addr", araddr | awaddr, 32'h0);
        areset = 0;
        tick();

        for (int i = 0; i < 8; i++) run_copy(tbl[i], $sformatf("vec%0d", i));

        // Reset while the write phase is in flight.
        stall_max = 0; bad_waddr = NONE;
        src_addr = 32'h000; dst_addr = 32'h900; len_words = LEN_W'(4); start = 1;
        tick();
        start = 0;
        k = 0;
        while (!awvalid && k < 50) begin tick(); k++; end
        chk("t6_awvalid_seen", {31'b0, awvalid}, 32'h1);
        chk("t6_wstrb_prot", {25'b0, wstrb, awprot}, {25'b0, 4'hF, 3'b000});
        chk("t6_arprot", {29'b0, arprot}, 32'h0);
        areset = 1;
        tick();
        chk("t6_valids", {27'b0, arvalid, awvalid, wvalid, rready, bready}, 32'h0);
        chk("t6_busy", {31'b0, busy}, 32'h0);
        areset = 0;
        tick();
        run_copy(mk(32'h000, 32'h900, 4, 0, NONE, 0, 0, 0, 32'h0, 16), "t6_clean");

        for (int i = 0; i < 6; i++) begin
            rv = mk(32'($urandom_range(99, 0)) * 4, 32'($urandom_range(999, 192)) * 4,
                    int'($urandom_range(12, 1)), int'($urandom_range(5, 0)), NONE, 0, 0, 0, 32'h0, -1);
            if (rv.stall == 0) rv.exp_lat = 4 * rv.len;
            run_copy(rv, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
